monostable_nch: RTL and testbench

Multi-channel, clocked, retriggerable monostable (one-shot) pulse generator. It is the parametrised successor of the team's dual-edge-triggered monostable. Each channel keeps the same trigger semantics: rising edge on TRP while TRN is high, or falling edge on TRN while TRP is low. Pulse width is a per-channel cycle count loaded at trigger time instead of an RC constant. The block sits between asynchronous event inputs and the synchronous control logic, producing cycle-exact gate pulses and end-of-pulse strobes.

---
 rtl/monostable_nch.sv | 116 +++++++++++
 tb/tb_monostable_nch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/monostable_nch.sv
// Multi-channel retriggerable monostable with synchronised dual-edge trigger.
// Define MONO_RETRIG_EN to reload the width counter on a trigger while ACTIVE.
module monostable_nch #(
  parameter int CH = 2,
  parameter int CW = 16
) (
  input  logic             CLK,
  input  logic             RD,
  input  logic [CH-1:0]    TRP,
  input  logic [CH-1:0]    TRN,
  input  logic [CH-1:0]    CLRN,
  input  logic [CH*CW-1:0] PW,
  output logic [CH-1:0]    Q,
  output logic [CH-1:0]    Qnot,
  output logic [CH-1:0]    DONE
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  localparam logic [CW-1:0] ONE = CW'(1);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic          p1_q, p2_q, p3_q;
    logic          n1_q, n2_q, n3_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [CW-1:0] pw;
    logic          trig;
    logic          fire;

    assign pw   = PW[i*CW +: CW];
    assign trig = (p2_q & ~p3_q & n2_q)
                | (~n2_q & n3_q & ~p2_q);
    assign fire = trig & (pw != '0);

    // TRN chain idles high so a release never fakes a falling edge
    always_ff @(posedge CLK or negedge RD) begin
      if (!RD) begin
        p1_q <= 1'b0;
        p2_q <= 1'b0;
        p3_q <= 1'b0;
        n1_q <= 1'b1;
        n2_q <= 1'b1;
        n3_q <= 1'b1;
      end else begin
        p1_q <= TRP[i];
        p2_q <= p1_q;
        p3_q <= p2_q;
        n1_q <= TRN[i];
        n2_q <= n1_q;
        n3_q <= n2_q;
      end
    end

    always_ff @(posedge CLK or negedge RD) begin
      if (!RD) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        done_q  <= done_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (!CLRN[i]) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (fire) begin
              state_d = ACTIVE;
              cnt_d   = pw - ONE;
            end
          end
          ACTIVE: begin
`ifdef MONO_RETRIG_EN
            if (fire) begin
              cnt_d = pw - ONE;
            end else if (cnt_q != '0) begin
              cnt_d = cnt_q - ONE;
            end
`else
            if (cnt_q != '0) begin
              cnt_d = cnt_q - ONE;
            end
`endif
            else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end

    assign Q[i]    = (state_q == ACTIVE);
    assign DONE[i] = done_q;
  end

  assign Qnot = ~Q;

endmodule

// File: tb/tb_monostable_nch.sv
// Directed bench for monostable_nch (CH=2, CW=8).
// Expected pulse timing is written out by hand per step.
module tb_monostable_nch;

  localparam int CH = 2;
  localparam int CW = 8;
`ifdef MONO_RETRIG_EN
  localparam int RW = 16;
`else
  localparam int RW = 10;
`endif

  logic             CLK = 1'b0;
  logic             RD;
  logic [CH-1:0]    TRP;
  logic [CH-1:0]    TRN;
  logic [CH-1:0]    CLRN;
  logic [CH*CW-1:0] PW;
  logic [CH-1:0]    Q;
  logic [CH-1:0]    Qnot;
  logic [CH-1:0]    DONE;

  int vectors = 0;
  int errs    = 0;

  monostable_nch #(
    .CH(CH),
    .CW(CW)
  ) dut (
    .CLK (CLK),
    .RD  (RD),
    .TRP (TRP),
    .TRN (TRN),
    .CLRN(CLRN),
    .PW  (PW),
    .Q   (Q),
    .Qnot(Qnot),
    .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic set_pw(input int ch, input int v);
    PW[ch*CW +: CW] = CW'(v);
  endtask

  task automatic quiet(input int n, input string tag);
    repeat (n) begin
      tick();
      chk({tag, " q"}, {Qnot, Q}, 4'b1100);
      chk({tag, " done"}, {2'b00, DONE}, 4'b0000);
    end
  endtask

  // trigger input already applied before the first edge here
  task automatic expect_pulse(input int ch, input int w,
                              input string tag);
    logic [1:0] m;
    m = 2'b01 << ch;
    repeat (2) begin
      tick();
      chk({tag, " lead"}, {Qnot, Q}, 4'b1100);
    end
    repeat (w) begin
      tick();
      chk({tag, " high"}, {Qnot, Q}, {~m, m});
      chk({tag, " done0"}, {2'b00, DONE}, 4'b0000);
    end
    tick();
    chk({tag, " fall"}, {Qnot, Q}, 4'b1100);
    chk({tag, " done"}, {2'b00, DONE}, {2'b00, m});
    tick();
    chk({tag, " done1"}, {2'b00, DONE}, 4'b0000);
  endtask

  initial begin
    RD   = 1'b0;
    TRP  = 2'b00;
    TRN  = 2'b11;
    CLRN = 2'b11;
    PW   = '0;
    set_pw(0, 5);
    set_pw(1, 3);
    #2;
    chk("rst q", {Qnot, Q}, 4'b1100);
    chk("rst done", {2'b00, DONE}, 4'b0000);
    tick();
    tick();
    RD = 1'b1;
    quiet(3, "idle");

    // positive trigger on ch0
    TRP[0] = 1'b1;
    expect_pulse(0, 5, "pos0");
    TRP[0] = 1'b0;
    quiet(3, "pos0 tail");

    // negative trigger on ch1
    TRN[1] = 1'b0;
    expect_pulse(1, 3, "neg1");
    TRP[1] = 1'b1;
    quiet(4, "trp1 rise trn low");
    TRN[1] = 1'b1;
    quiet(4, "trn1 rise");
    TRN[1] = 1'b0;
    quiet(4, "trn1 fall trp high");
    TRP[1] = 1'b0;
    quiet(3, "trp1 fall");
    TRN[1] = 1'b1;
    quiet(3, "trn1 restore");

    // edge swallowed by clear, then TRP rise gated by TRN low
    CLRN[0] = 1'b0;
    TRN[0]  = 1'b0;
    quiet(5, "clrn swallow");
    CLRN[0] = 1'b1;
    quiet(2, "clrn release");
    TRP[0] = 1'b1;
    quiet(5, "trp0 rise trn low");
    TRP[0] = 1'b0;
    quiet(3, "trp0 fall");
    TRN[0] = 1'b1;
    quiet(3, "trn0 restore");

    // second trigger lands six cycles into a 10-cycle pulse
    set_pw(0, 10);
    TRP[0] = 1'b1;
    repeat (2) begin
      tick();
      chk("retrig lead", {Qnot, Q}, 4'b1100);
    end
    for (int h = 1; h <= RW; h++) begin
      tick();
      chk("retrig high", {Qnot, Q}, 4'b1001);
      chk("retrig done0", {2'b00, DONE}, 4'b0000);
      if (h == 1) TRP[0] = 1'b0;
      if (h == 4) TRP[0] = 1'b1;
    end
    tick();
    chk("retrig fall", {Qnot, Q}, 4'b1100);
    chk("retrig done", {2'b00, DONE}, 4'b0001);
    TRP[0] = 1'b0;
    quiet(4, "retrig tail");

    // PW = 0 ignored
    set_pw(0, 0);
    TRP[0] = 1'b1;
    quiet(8, "pw0");
    TRP[0] = 1'b0;
    quiet(3, "pw0 tail");

    set_pw(0, 1);
    TRP[0] = 1'b1;
    expect_pulse(0, 1, "pw1");
    TRP[0] = 1'b0;
    quiet(3, "pw1 tail");

    set_pw(0, 255);
    TRP[0] = 1'b1;
    expect_pulse(0, 255, "pwmax");
    TRP[0] = 1'b0;
    quiet(3, "pwmax tail");

    // clear during cycle 4 of an 8-cycle pulse
    set_pw(0, 8);
    TRP[0] = 1'b1;
    repeat (2) begin
      tick();
      chk("clr lead", {Qnot, Q}, 4'b1100);
    end
    repeat (4) begin
      tick();
      chk("clr high", {Qnot, Q}, 4'b1001);
    end
    CLRN[0] = 1'b0;
    tick();
    chk("clr fall", {Qnot, Q}, 4'b1100);
    chk("clr done", {2'b00, DONE}, 4'b0000);
    tick();
    chk("clr done1", {2'b00, DONE}, 4'b0000);
    CLRN[0] = 1'b1;
    TRP[0]  = 1'b0;
    quiet(3, "clr tail");

    // async reset mid-pulse, then release with TRP/TRN high
    TRP[0] = 1'b1;
    repeat (2) begin
      tick();
      chk("rd lead", {Qnot, Q}, 4'b1100);
    end
    repeat (3) begin
      tick();
      chk("rd high", {Qnot, Q}, 4'b1001);
    end
    #2;
    RD = 1'b0;
    #1;
    chk("rd async q", {Qnot, Q}, 4'b1100);
    chk("rd async done", {2'b00, DONE}, 4'b0000);
    #2;
    RD = 1'b1;
    expect_pulse(0, 8, "rd release");
    TRP[0] = 1'b0;
    quiet(3, "end");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
